pwm_duty_meter: RTL and testbench



---
 rtl/pwm_duty_meter.sv | 140 ++++++++++++++
 tb/tb_pwm_duty_meter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// PWM capture: measures the period and high time of an incoming PWM waveform in clk cycles.
// Rising-edge-to-rising-edge measurement; a constant input is reported as stuck after TIMEOUT cycles.
module pwm_duty_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_armed;
    logic             r_stuck;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_stuck_high;
    logic             r_stuck_low;

    logic             w_rise;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_hcnt_inc;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_hcnt_d;
    logic             w_armed_d;
    logic             w_stuck_d;
    logic [CNT_W-1:0] w_period_d;
    logic [CNT_W-1:0] w_high_d;
    logic             w_valid_d;
    logic             w_stuck_high_d;
    logic             w_stuck_low_d;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= pwm_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_rise    = r_s2 & ~r_prev;
    assign w_timeout = ~w_rise & ~r_stuck & (r_cnt == TMO_M1);

    // Counters saturate at TIMEOUT so a long stuck input never wraps into a bogus value.
    assign w_cnt_inc  = (r_cnt >= TMO) ? TMO : r_cnt + ONE;
    assign w_hcnt_inc = (r_s2 && (r_hcnt < TMO)) ? r_hcnt + ONE : r_hcnt;

    always_comb begin
        w_cnt_d        = r_cnt;
        w_hcnt_d       = r_hcnt;
        w_armed_d      = r_armed;
        w_stuck_d      = r_stuck;
        w_period_d     = r_period;
        w_high_d       = r_high;
        w_valid_d      = 1'b0;
        w_stuck_high_d = r_stuck_high;
        w_stuck_low_d  = r_stuck_low;

        if (w_rise) begin
            w_cnt_d        = ONE;
            w_hcnt_d       = ONE;
            w_armed_d      = 1'b1;
            w_stuck_d      = 1'b0;
            w_stuck_high_d = 1'b0;
            w_stuck_low_d  = 1'b0;
            // The first rise after reset or a stuck condition only opens the window.
            if (r_armed) begin
                w_period_d = r_cnt;
                w_high_d   = r_hcnt;
                w_valid_d  = 1'b1;
            end
        end else begin
            w_cnt_d  = w_cnt_inc;
            w_hcnt_d = w_hcnt_inc;
            if (w_timeout) begin
                w_stuck_d      = 1'b1;
                w_armed_d      = 1'b0;
                w_period_d     = '0;
                w_high_d       = '0;
                w_valid_d      = 1'b1;
                w_stuck_high_d = r_s2;
                w_stuck_low_d  = ~r_s2;
            end else if (r_stuck) begin
                w_stuck_high_d = r_s2;
                w_stuck_low_d  = ~r_s2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_armed      <= 1'b0;
            r_stuck      <= 1'b0;
            r_period     <= '0;
            r_high       <= '0;
            r_valid      <= 1'b0;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_d;
            r_hcnt       <= w_hcnt_d;
            r_armed      <= w_armed_d;
            r_stuck      <= w_stuck_d;
            r_period     <= w_period_d;
            r_high       <= w_high_d;
            r_valid      <= w_valid_d;
            r_stuck_high <= w_stuck_high_d;
            r_stuck_low  <= w_stuck_low_d;
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign meas_valid = r_valid;
    assign stuck_high = r_stuck_high;
    assign stuck_low  = r_stuck_low;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter with TIMEOUT=200; expectations are hand-computed cycle counts.
module tb_pwm_duty_meter;

    logic        clk;
    logic        reset;
    logic        pwm_in;
    logic [15:0] period_out;
    logic [15:0] high_out;
    logic        meas_valid;
    logic        stuck_high;
    logic        stuck_low;

    int n_assert = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int last_p    = 0;
    int last_h    = 0;
    int dbl       = 0;
    logic prev_v  = 1'b0;

    pwm_duty_meter #(
        .CNT_W  (16),
        .TIMEOUT(200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .period_out(period_out),
        .high_out  (high_out),
        .meas_valid(meas_valid),
        .stuck_high(stuck_high),
        .stuck_low (stuck_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every valid pulse just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (meas_valid) begin
            valid_cnt = valid_cnt + 1;
            last_p    = int'(period_out);
            last_h    = int'(high_out);
            if (prev_v) dbl = dbl + 1;
        end
        prev_v = meas_valid;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_meas(input string tag, input int nv, input int p, input int h);
        check({tag, " valid_count"}, valid_cnt, nv);
        check({tag, " period"}, last_p, p);
        check({tag, " high"}, last_h, h);
    endtask

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pp(input int h, input int p);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    initial begin
        pwm_in = 1'b0;
        reset  = 1'b0;
        #3 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst period_out", period_out, 0);
        check("rst high_out", high_out, 0);
        check("rst meas_valid", meas_valid, 0);
        check("rst stuck_high", stuck_high, 0);
        check("rst stuck_low", stuck_low, 0);
        reset = 1'b0;

        // Period 100, high 25: first rise only arms.
        pp(25, 100);
        check("p1 no valid", valid_cnt, 0);
        pp(25, 100);
        check_meas("p2", 1, 100, 25);
        pp(25, 100);
        check_meas("p3", 2, 100, 25);
        check("p3 hold period_out", period_out, 100);
        check("p3 meas_valid low", meas_valid, 0);

        // Duty change to 75, then short period 10.
        pp(75, 100);
        check_meas("d4", 3, 100, 25);
        pp(75, 100);
        check_meas("d5", 4, 100, 75);
        pp(1, 10);
        check_meas("d6", 5, 100, 75);
        pp(1, 10);
        check_meas("d7", 6, 10, 1);
        pp(9, 10);
        check_meas("d8", 7, 10, 1);
        hold(1'b1, 5);
        check_meas("d9", 8, 10, 9);

        // Async reset between clock edges, mid-period.
        hold(1'b1, 20);
        hold(1'b0, 40);
        #2 reset = 1'b1;
        #1;
        check("arst period_out", period_out, 0);
        check("arst high_out", high_out, 0);
        check("arst meas_valid", meas_valid, 0);
        check("arst stuck_high", stuck_high, 0);
        check("arst stuck_low", stuck_low, 0);
        @(negedge clk);
        reset = 1'b0;
        pp(25, 100);
        check("arst first rise", valid_cnt, 8);
        pp(25, 100);
        check_meas("arst second rise", 9, 100, 25);

        // Stuck low after reset: timeout on the 200th edge after release.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 199);
        check("sl pre valid", valid_cnt, 9);
        check("sl pre stuck_low", stuck_low, 0);
        hold(1'b0, 1);
        check_meas("sl fire", 10, 0, 0);
        check("sl stuck_low", stuck_low, 1);
        check("sl stuck_high", stuck_high, 0);
        hold(1'b0, 50);
        check("sl single valid", valid_cnt, 10);
        check("sl still stuck", stuck_low, 1);
        hold(1'b1, 25);
        check("sl clear stuck_low", stuck_low, 0);
        check("sl clear stuck_high", stuck_high, 0);
        check("sl rearm no valid", valid_cnt, 10);
        hold(1'b0, 25);
        hold(1'b1, 5);
        check_meas("sl period50", 11, 50, 25);

        // Stuck high: rise, then input stays high until timeout at the 202nd edge.
        hold(1'b1, 20);
        hold(1'b0, 75);
        hold(1'b1, 5);
        check_meas("sh meas", 12, 100, 25);
        hold(1'b1, 196);
        check("sh pre valid", valid_cnt, 12);
        check("sh pre stuck_high", stuck_high, 0);
        hold(1'b1, 1);
        check("sh fire valid", valid_cnt, 13);
        check("sh period_out", period_out, 0);
        check("sh high_out", high_out, 0);
        check("sh stuck_high", stuck_high, 1);
        check("sh stuck_low", stuck_low, 0);
        hold(1'b0, 5);
        check("sh drop stuck_low", stuck_low, 1);
        check("sh drop stuck_high", stuck_high, 0);
        check("sh drop no valid", valid_cnt, 13);

        // Single-cycle glitch inside a low phase.
        pp(10, 100);
        check("g rearm", valid_cnt, 13);
        check("g stuck_low clear", stuck_low, 0);
        pp(10, 40);
        check_meas("g full", 14, 100, 10);
        pp(1, 30);
        check_meas("g glitch", 15, 40, 10);
        hold(1'b1, 5);
        check_meas("g after glitch", 16, 30, 1);

        check("valid single cycle", dbl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
